prga_decrypt_fsm: RTL and testbench
===================================

Name: prga_decrypt_fsm

Overview:
RC4 pseudo-random generation and decrypt stage. It runs directly downstream of the key-scheduling FSM. After the controller's start pulse, it reads the scheduled S memory and generates one keystream byte per message byte. Each keystream byte is XORed with the encrypted message ROM byte and the result is written to the decrypted-message RAM. S-memory outputs share the top-level OR bus with the other task FSMs, so every bus output is 0 whenever the block is not actively driving it.

Parameters:
MSG_LEN, 32, number of message bytes processed (1..256)
ADDR_W, 5, width of ROM/decrypted-RAM address; must satisfy 2**ADDR_W >= MSG_LEN

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle start pulse from controller; sampled only in IDLE
finish  out  1  one-cycle pulse when all MSG_LEN bytes have been written
valid  out  1  result flag, registered, updated at finish
s_address  out  8  S memory address (0 when not driving)
s_data  out  8  S memory write data (0 when not writing)
s_wren  out  1  S memory write enable
s_q  in  8  S memory read data, valid 1 cycle after address
rom_address  out  ADDR_W  encrypted ROM address
rom_q  in  8  encrypted ROM data, valid 1 cycle after address
dec_address  out  ADDR_W  decrypted RAM address (0 when not writing)
dec_data  out  8  decrypted RAM write data (0 when not writing)
dec_wren  out  1  decrypted RAM write enable

Behaviour:
- Reset (reset_n=0 at a clock edge) applies in any state, including mid-message:
  - state=IDLE; i, j, k, si, sj, f cleared.
  - All outputs 0, except valid=1.
  - No further writes occur.
- Algorithm, all arithmetic 8-bit mod 256 (k is an ADDR_W-bit index):
  - On start: i=1, j=0, k=0.
  - Per byte: j=j+S[i]; swap S[i],S[j]; f=S[(S[i]+S[j]) mod 256]; dec[k]=f XOR enc[k]; then i++, k++.
- Per-byte states, one cycle each, 10 cycles per byte:
  - ADDR_I: s_address=i.
  - GET_I: si<=s_q; j<=j+s_q.
  - ADDR_J: s_address=j (the updated j).
  - GET_J: sj<=s_q.
  - WR_I: s_address=i, s_data=sj, s_wren=1.
  - WR_J: s_address=j, s_data=si, s_wren=1.
  - ADDR_F: s_address=si+sj; rom_address=k.
  - GET_F: f<=s_q; e<=rom_q.
  - WR_DEC: dec_address=k, dec_data=f^e, dec_wren=1.
  - NEXT: if k==MSG_LEN-1 go to DONE, else i++, k++, go to ADDR_I.
- Timing:
  - IDLE with start=1 at edge t: ADDR_I at t+1.
  - DONE occupies cycle t+1+10*MSG_LEN; finish=1 for exactly that cycle; then IDLE.
- i==j: both writes target the same address with the same value; the result equals a no-op swap. No special-casing.
- start while not in IDLE is ignored. start held high in IDLE re-launches after DONE→IDLE.
- s_address, s_data and s_wren are 0 in IDLE, GET_*, WR_DEC, NEXT and DONE. This is required by the OR bus.
- rom_address and dec_address may hold k outside their active states; dec_wren is high only in WR_DEC.

Optional Feature:
PRGA_ASCII_CHECK_EN.
- Defined: in WR_DEC, a byte (f^e) not in 0x61..0x7A and not 0x20 is not written (dec_wren=0). The FSM jumps straight to DONE; finish pulses; valid=0. A fully completed message gives valid=1. valid is cleared to 1 on each start.
- Undefined: all bytes are always written and valid is constant 1.

Test Plan:
1. Identity S (S[x]=x), MSG_LEN=2, enc={0x41,0x40}, start at t.
   - dec[0]=0x43, dec[1]=0x45.
   - S[2]=3, S[3]=2, all other S unchanged.
   - finish high only at cycle t+21.
2. Wrap: S identity except S[1]=0x80, S[0x80]=0x90, MSG_LEN=1, enc[0]=0x00.
   - j=0x80; after swap S[1]=0x90, S[0x80]=0x80.
   - f address (0x80+0x90) mod 256 = 0x10, so dec[0]=0x10.
3. Bus quiescence: during IDLE, and during GET/NEXT/DONE cycles of test 1, s_address, s_data and s_wren are all 0. start pulses mid-run cause no change to the output trace.
4. Reset mid-op: reset_n=0 for one cycle during WR_J of byte 0.
   - Next cycle all outputs are 0 and the state is IDLE; no dec_wren follows.
   - A new start reruns test 1 correctly.
5. MSG_LEN=32 with the full 32-byte RC4 reference vector (S produced by the upstream stages with key 0x000249): all 32 bytes match the golden model; finish exactly once, 321 cycles after start.
6. With PRGA_ASCII_CHECK_EN: decrypted stream "ab" followed by 0x07.
   - Bytes 0–1 written; byte 2 not written.
   - finish pulses after byte 2's WR_DEC, with valid=0.
   - An all-lowercase stream gives valid=1.

Source files
------------

// File: rtl/prga_decrypt_fsm.sv
`default_nettype none
// ============================================================================
// Module      : prga_decrypt_fsm
// Description : RC4 pseudo-random generation and decrypt stage. Reads the
//               scheduled S memory, produces one keystream byte per message
//               byte, XORs it with the encrypted ROM byte and writes the
//               result to the decrypted-message RAM. S-memory outputs are
//               zero whenever the block is not driving the shared OR bus.
// Options     : PRGA_ASCII_CHECK_EN - abort the message on the first
//               decrypted byte that is not lowercase a..z or space, and
//               report it through valid.
// Revision    : 1.0 - initial release
// ============================================================================
module prga_decrypt_fsm #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              finish,
  output logic              valid,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] dec_address,
  output logic [7:0]        dec_data,
  output logic              dec_wren
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] ADDR_I = 4'd1;
  localparam logic [3:0] GET_I  = 4'd2;
  localparam logic [3:0] ADDR_J = 4'd3;
  localparam logic [3:0] GET_J  = 4'd4;
  localparam logic [3:0] WR_I   = 4'd5;
  localparam logic [3:0] WR_J   = 4'd6;
  localparam logic [3:0] ADDR_F = 4'd7;
  localparam logic [3:0] GET_F  = 4'd8;
  localparam logic [3:0] WR_DEC = 4'd9;
  localparam logic [3:0] NEXT   = 4'd10;
  localparam logic [3:0] DONE   = 4'd11;

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

  logic [3:0]        state;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic [7:0]        f;
  logic [7:0]        e;
  logic [ADDR_W-1:0] k;
  logic [7:0]        dec_byte;
  logic              byte_ok;

  assign dec_byte = f ^ e;

`ifdef PRGA_ASCII_CHECK_EN
  assign byte_ok = ((dec_byte >= 8'h61) && (dec_byte <= 8'h7A)) || (dec_byte == 8'h20);
`else
  assign byte_ok = 1'b1;
`endif

  // Sequencer: walks the ten per-byte steps and keeps the RC4 indices/bytes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      i     <= 8'd0;
      j     <= 8'd0;
      k     <= '0;
      si    <= 8'd0;
      sj    <= 8'd0;
      f     <= 8'd0;
      e     <= 8'd0;
      valid <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ADDR_I;
            i     <= 8'd1;
            j     <= 8'd0;
            k     <= '0;
            valid <= 1'b1;
          end
        end
        ADDR_I: state <= GET_I;
        GET_I: begin
          si    <= s_q;
          j     <= j + s_q;
          state <= ADDR_J;
        end
        ADDR_J: state <= GET_J;
        GET_J: begin
          sj    <= s_q;
          state <= WR_I;
        end
        WR_I:   state <= WR_J;
        WR_J:   state <= ADDR_F;
        ADDR_F: state <= GET_F;
        GET_F: begin
          f     <= s_q;
          e     <= rom_q;
          state <= WR_DEC;
        end
        WR_DEC: begin
          if (byte_ok) begin
            state <= NEXT;
          end else begin
            state <= DONE;
            valid <= 1'b0;
          end
        end
        NEXT: begin
          if (k == LAST_K) begin
            state <= DONE;
          end else begin
            i     <= i + 8'd1;
            k     <= k + 1'b1;
            state <= ADDR_I;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode: bus outputs are driven only in the states that use them.
  always_comb begin
    s_address   = 8'd0;
    s_data      = 8'd0;
    s_wren      = 1'b0;
    dec_address = '0;
    dec_data    = 8'd0;
    dec_wren    = 1'b0;
    case (state)
      ADDR_I: s_address = i;
      ADDR_J: s_address = j;
      WR_I: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
      end
      WR_J: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
      end
      ADDR_F: s_address = si + sj;
      WR_DEC: begin
        if (byte_ok) begin
          dec_address = k;
          dec_data    = dec_byte;
          dec_wren    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rom_address = k;
  assign finish      = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_prga_decrypt_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_prga_decrypt_fsm
// Description : Directed self-checking bench for prga_decrypt_fsm. Four DUT
//               instances (MSG_LEN 2, 1, 32, 3) share one S memory through an
//               OR bus and one encrypted ROM selected by the active instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prga_decrypt_fsm;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [3:0]       start_v;
  logic [3:0]       fin_v, val_v, sw_v, dw_v;
  logic [3:0][7:0]  sa_v, sd_v, dd_v;
  logic [3:0][4:0]  ra_v, da_v;
  logic [7:0]       s_q, rom_q;
  logic [7:0]       s_addr_bus, s_data_bus;
  logic             s_wren_bus;

  logic [7:0] smem     [256];
  logic [7:0] s_init   [256];
  logic [7:0] rom_init [32];
  logic [7:0] dec_cap  [32];
  logic [7:0] ms       [256];
  logic [7:0] ks       [32];
  logic [7:0] key      [3];
  logic [7:0] mi, mj, tmp, fa;
  logic       load;
  int         sel;
  int         tests = 0;
  int         fails = 0;
  int         wr_cnt, fin_cnt, bad;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LEN = (g == 0) ? 2 : ((g == 1) ? 1 : ((g == 2) ? 32 : 3));
    prga_decrypt_fsm #(.MSG_LEN(LEN), .ADDR_W(5)) u_dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start_v[g]),
      .finish      (fin_v[g]),
      .valid       (val_v[g]),
      .s_address   (sa_v[g]),
      .s_data      (sd_v[g]),
      .s_wren      (sw_v[g]),
      .s_q         (s_q),
      .rom_address (ra_v[g]),
      .rom_q       (rom_q),
      .dec_address (da_v[g]),
      .dec_data    (dd_v[g]),
      .dec_wren    (dw_v[g])
    );
  end

  // Shared S-memory OR bus.
  always_comb begin
    s_addr_bus = 8'd0;
    s_data_bus = 8'd0;
    s_wren_bus = 1'b0;
    for (int g = 0; g < 4; g++) begin
      s_addr_bus = s_addr_bus | sa_v[g];
      s_data_bus = s_data_bus | sd_v[g];
      s_wren_bus = s_wren_bus | sw_v[g];
    end
  end

  // Synchronous-read S memory and ROM models.
  always @(posedge clock) begin
    s_q   <= smem[s_addr_bus];
    rom_q <= rom_init[ra_v[sel]];
    if (load) begin
      for (int x = 0; x < 256; x++) smem[x] = s_init[x];
    end else if (s_wren_bus) begin
      smem[s_addr_bus] = s_data_bus;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clock);
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic identity_s();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  // Launch instance g and watch every cycle up to two past the expected DONE.
  task automatic run_msg(input int g, input int done_n, input int inj_n);
    int phase;
    bit quiet;
    for (int x = 0; x < 32; x++) dec_cap[x] = 8'h00;
    wr_cnt  = 0;
    fin_cnt = 0;
    sel     = g;
    @(negedge clock);
    start_v[g] = 1'b1;
    @(negedge clock);
    start_v[g] = 1'b0;
    for (int n = 1; n <= done_n + 2; n++) begin
      phase = (n - 1) % 10;
      quiet = (n >= done_n) || (phase == 1) || (phase == 3) || (phase >= 7);
      if (quiet)
        chk($sformatf("bus_quiet g%0d n%0d", g, n),
            64'({s_addr_bus, s_data_bus, s_wren_bus}), 64'd0);
      chk($sformatf("finish g%0d n%0d", g, n), 64'(fin_v[g]), 64'(n == done_n));
      if (dw_v[g]) begin
        chk($sformatf("wren_phase g%0d n%0d", g, n), 64'(phase), 64'd8);
        dec_cap[da_v[g]] = dd_v[g];
        wr_cnt++;
      end
      if (fin_v[g]) fin_cnt++;
      start_v[g] = (n == inj_n);
      @(negedge clock);
    end
    start_v[g] = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start_v = 4'd0;
    sel     = 0;
    for (int x = 0; x < 32; x++) rom_init[x] = 8'h00;
    identity_s();
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;

    // Reset state of every instance.
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_outs g%0d", g),
          64'({fin_v[g], sa_v[g], sd_v[g], sw_v[g], ra_v[g], da_v[g], dd_v[g], dw_v[g]}), 64'd0);
      chk($sformatf("rst_valid g%0d", g), 64'(val_v[g]), 64'd1);
    end
    reset_n = 1'b1;

    // Identity S, two bytes.
    rom_init[0] = 8'h41;
    rom_init[1] = 8'h40;
    load_mem();
    run_msg(0, 21, 0);
    chk("t1_dec0", 64'(dec_cap[0]), 64'h43);
    chk("t1_dec1", 64'(dec_cap[1]), 64'h45);
    chk("t1_wr_cnt", 64'(wr_cnt), 64'd2);
    chk("t1_fin_cnt", 64'(fin_cnt), 64'd1);
    chk("t1_s2", 64'(smem[2]), 64'h03);
    chk("t1_s3", 64'(smem[3]), 64'h02);
    bad = 0;
    for (int x = 0; x < 256; x++)
      if (x != 2 && x != 3 && smem[x] != 8'(x)) bad++;
    chk("t1_s_rest", 64'(bad), 64'd0);

    // Same run with a stray start pulse mid-message.
    load_mem();
    run_msg(0, 21, 15);
    chk("t3_dec0", 64'(dec_cap[0]), 64'h43);
    chk("t3_dec1", 64'(dec_cap[1]), 64'h45);
    chk("t3_fin_cnt", 64'(fin_cnt), 64'd1);

    // Reset during WR_J of byte 0.
    load_mem();
    sel = 0;
    @(negedge clock);
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clock);
    chk("t4_wr_j_bus", 64'({s_addr_bus, s_data_bus, s_wren_bus}), 64'({8'h01, 8'h01, 1'b1}));
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("t4_outs_zero",
        64'({fin_v[0], sa_v[0], sd_v[0], sw_v[0], ra_v[0], da_v[0], dd_v[0], dw_v[0]}), 64'd0);
    chk("t4_valid", 64'(val_v[0]), 64'd1);
    bad = 0;
    for (int n = 0; n < 25; n++) begin
      if (dw_v[0] || fin_v[0] || s_wren_bus) bad++;
      @(negedge clock);
    end
    chk("t4_no_activity", 64'(bad), 64'd0);
    load_mem();
    run_msg(0, 21, 0);
    chk("t4_rerun_dec0", 64'(dec_cap[0]), 64'h43);
    chk("t4_rerun_dec1", 64'(dec_cap[1]), 64'h45);

    // Index wrap, one byte.
    identity_s();
    s_init[1]    = 8'h80;
    s_init[8'h80] = 8'h90;
    rom_init[0]  = 8'h00;
    load_mem();
    run_msg(1, 11, 0);
    chk("t2_dec0", 64'(dec_cap[0]), 64'h10);
    chk("t2_s1", 64'(smem[1]), 64'h90);
    chk("t2_s80", 64'(smem[8'h80]), 64'h80);

    // Full 32-byte message, S from the key schedule with key 00 02 49.
    key[0] = 8'h00;
    key[1] = 8'h02;
    key[2] = 8'h49;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    mj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      mj     = mj + ms[x] + key[x % 3];
      tmp    = ms[x];
      ms[x]  = ms[mj];
      ms[mj] = tmp;
    end
    for (int x = 0; x < 256; x++) s_init[x] = ms[x];
    mi = 8'd0;
    mj = 8'd0;
    for (int x = 0; x < 32; x++) begin
      mi     = mi + 8'd1;
      mj     = mj + ms[mi];
      tmp    = ms[mi];
      ms[mi] = ms[mj];
      ms[mj] = tmp;
      fa     = ms[mi] + ms[mj];
      ks[x]  = ms[fa];
      rom_init[x] = 8'(x * 37 + 11);
    end
    load_mem();
    run_msg(2, 321, 0);
    for (int x = 0; x < 32; x++)
      chk($sformatf("t5_dec%0d", x), 64'(dec_cap[x]), 64'(ks[x] ^ rom_init[x]));
    chk("t5_wr_cnt", 64'(wr_cnt), 64'd32);
    chk("t5_fin_cnt", 64'(fin_cnt), 64'd1);

    // Decrypted stream "ab", 0x07 (keystream with identity S is 02 05 07).
    identity_s();
    rom_init[0] = 8'h63;
    rom_init[1] = 8'h67;
    rom_init[2] = 8'h00;
    load_mem();
`ifdef PRGA_ASCII_CHECK_EN
    run_msg(3, 30, 0);
    chk("t6_wr_cnt", 64'(wr_cnt), 64'd2);
    chk("t6_valid", 64'(val_v[3]), 64'd0);
`else
    run_msg(3, 31, 0);
    chk("t6_wr_cnt", 64'(wr_cnt), 64'd3);
    chk("t6_dec2", 64'(dec_cap[2]), 64'h07);
    chk("t6_valid", 64'(val_v[3]), 64'd1);
`endif
    chk("t6_dec0", 64'(dec_cap[0]), 64'h61);
    chk("t6_dec1", 64'(dec_cap[1]), 64'h62);
    chk("t6_fin_cnt", 64'(fin_cnt), 64'd1);

    // All-lowercase "abc" completes with valid set.
    rom_init[2] = 8'h64;
    load_mem();
    run_msg(3, 31, 0);
    chk("t6b_wr_cnt", 64'(wr_cnt), 64'd3);
    chk("t6b_dec2", 64'(dec_cap[2]), 64'h63);
    chk("t6b_valid", 64'(val_v[3]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
